// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer for a block-breaker game.
// Tracks state, level, lives and score; all outputs are registered.
//
// Ports:
//   clk               single clock
//   rst               async active-low reset
//   iFrame_tick       one-cycle strobe per video frame
//   iStart            start/launch button (level, edge-detected inside)
//   iBallDie          ball below floor line
//   iSpecial_attacked ball inside special-block window
//   iState_flag       300-bit live block field (20x15), 1 = block
//   oLevel            level index 0..2
//   oField_rst_n      active-low reload strobe to block datapath
//   oBall_run         ball motion enable
//   oSpecial_block    special block present
//   oLives            remaining lives
//   oScore            saturating score
//   oState            FSM state encoding
module game_flow_ctrl #(
  parameter int          LIVES_INIT   = 3,
  parameter int          WAIT_FRAMES  = 60,
  parameter int          SERVE_FRAMES = 120,
  // score loaded at game start; nonzero only for bring-up
  parameter logic [15:0] SCORE_INIT   = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iFrame_tick,
  input  logic         iStart,
  input  logic         iBallDie,
  input  logic         iSpecial_attacked,
  input  logic [299:0] iState_flag,
  output logic [1:0]   oLevel,
  output logic         oField_rst_n,
  output logic         oBall_run,
  output logic         oSpecial_block,
  output logic [1:0]   oLives,
  output logic [15:0]  oScore,
  output logic [2:0]   oState
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SERVE = 3'd2,
    S_PLAY  = 3'd3,
    S_DIE   = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6,
    S_WIN   = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic          field_rst_n_q, field_rst_n_d;
  logic          ball_run_q, ball_run_d;
  logic          special_q, special_d;
  logic [1:0]    lives_q, lives_d;
  logic [15:0]   score_q, score_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          load_q, load_d;
  logic          start_q, start_d;
  logic          spec_q, spec_d;
  logic [8:0]    prev_cnt_q, prev_cnt_d;

  logic [8:0]    cur_cnt;
  logic [8:0]    drop;
  logic [17:0]   sum;
  logic [15:0]   sat_score;
  logic          start_rise;
  logic          spec_rise;
  logic          hit;
  logic          field_empty;
  logic          serve_done;
  logic          wait_done;
  logic          entering;

  // popcount of the block field
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < 300; i++) begin
      cur_cnt = cur_cnt + 9'(iState_flag[i]);
    end
  end

  always_comb begin
    start_rise  = iStart & ~start_q;
    spec_rise   = iSpecial_attacked & ~spec_q;
    hit         = spec_rise & special_q;
    field_empty = ~|iState_flag;
    serve_done  = iFrame_tick &&
                  (frame_cnt_q == CW'(SERVE_FRAMES - 1));
    wait_done   = iFrame_tick &&
                  (frame_cnt_q == CW'(WAIT_FRAMES - 1));
    // blocks only ever score when they disappear
    drop        = (prev_cnt_q > cur_cnt) ?
                  (prev_cnt_q - cur_cnt) : 9'd0;
    sum         = 18'(score_q) + 18'(drop) +
                  (hit ? 18'd10 : 18'd0);
    sat_score   = (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    special_d  = special_q;
    lives_d    = lives_q;
    score_d    = score_q;
    start_d    = iStart;
    spec_d     = iSpecial_attacked;
    prev_cnt_d = cur_cnt;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_LOAD;
          level_d = 2'd0;
          lives_d = 2'(LIVES_INIT);
          score_d = SCORE_INIT;
        end
      end
      S_LOAD: begin
        if (load_q) begin
          state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (start_rise || serve_done) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        score_d = sat_score;
        if (hit) begin
          special_d = 1'b0;
        end
        // an empty field outranks a lost ball
        if (field_empty) begin
          state_d = S_CLEAR;
        end else if (iBallDie) begin
          state_d = S_DIE;
          lives_d = lives_q - 2'd1;
        end
      end
      S_DIE: begin
        // lives already decremented: zero means last life gone
        if (lives_q == 2'd0) begin
          state_d = S_OVER;
        end else if (wait_done) begin
          state_d = S_SERVE;
        end
      end
      S_CLEAR: begin
        if (wait_done) begin
          if (level_q == 2'd2) begin
            state_d = S_WIN;
          end else begin
            state_d = S_LOAD;
            level_d = level_q + 2'd1;
          end
        end
      end
      S_OVER, S_WIN: begin
        if (start_rise) begin
          state_d = S_IDLE;
        end
      end
    endcase

    entering    = (state_d != state_q);
    frame_cnt_d = entering ? '0 :
                  frame_cnt_q + CW'(iFrame_tick);
    // load_q marks the second LOAD cycle
    load_d      = (state_q == S_LOAD) && !entering;
    if (entering && state_d == S_LOAD) begin
      special_d = 1'b1;
    end
    field_rst_n_d = (state_d != S_LOAD);
    ball_run_d    = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      level_q       <= '0;
      field_rst_n_q <= 1'b0;
      ball_run_q    <= 1'b0;
      special_q     <= 1'b0;
      lives_q       <= '0;
      score_q       <= '0;
      frame_cnt_q   <= '0;
      load_q        <= 1'b0;
      start_q       <= 1'b0;
      spec_q        <= 1'b0;
      prev_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      field_rst_n_q <= field_rst_n_d;
      ball_run_q    <= ball_run_d;
      special_q     <= special_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      load_q        <= load_d;
      start_q       <= start_d;
      spec_q        <= spec_d;
      prev_cnt_q    <= prev_cnt_d;
    end
  end

  assign oLevel         = level_q;
  assign oField_rst_n   = field_rst_n_q;
  assign oBall_run      = ball_run_q;
  assign oSpecial_block = special_q;
  assign oLives         = lives_q;
  assign oScore         = score_q;
  assign oState         = state_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start, range 1..3.
REQ-002 SHALL have parameter WAIT_FRAMES, default 60: frame ticks spent in DIE and CLEAR.
REQ-003 SHALL have parameter SERVE_FRAMES, default 120: frame ticks in SERVE before auto-launch.
REQ-004 SHALL have port clk, input, 1: single clock for all state.
REQ-005 SHALL have port rst, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port iFrame_tick, input, 1: one-cycle strobe per video frame.
REQ-007 SHALL have port iStart, input, 1: start/launch button, level-sensitive; internally rising-edge detected.
REQ-008 SHALL have port iBallDie, input, 1: ball below the floor line.
REQ-009 SHALL have port iSpecial_attacked, input, 1: ball inside the special-block window.
REQ-010 SHALL have port iState_flag, input, 300: live block field, 20 columns x 15 rows, 1 = block present.
REQ-011 SHALL have port oLevel, output, 2: level index 0..2 for the block datapath.
REQ-012 SHALL have port oField_rst_n, output, 1: active-low reload strobe to the block datapath.
REQ-013 SHALL have port oBall_run, output, 1: ball motion enable.
REQ-014 SHALL have port oSpecial_block, output, 1: special block present.
REQ-015 SHALL have port oLives, output, 2: remaining lives.
REQ-016 SHALL have port oScore, output, 16: score.
REQ-017 SHALL have port oState, output, 3: encoding IDLE=0, LOAD=1, SERVE=2, PLAY=3, DIE=4, CLEAR=5, OVER=6, WIN=7.

Function
REQ-018 SHALL use a registered Moore FSM; all outputs SHALL be registered.
REQ-019 IDLE: on an iStart rising edge, SHALL set oLevel=0, oLives=LIVES_INIT and oScore=0, then go to LOAD.
REQ-020 LOAD: SHALL drive oField_rst_n=0 for exactly 2 cycles, set oSpecial_block=1, then go to SERVE.
REQ-021 SERVE: oBall_run=0; SHALL go to PLAY on an iStart rising edge or after SERVE_FRAMES frame ticks, whichever comes first.
REQ-022 PLAY: oBall_run=1; conditions SHALL be evaluated in priority order: field empty (iState_flag==0) -> CLEAR, then iBallDie -> DIE.
REQ-023 Scoring in PLAY SHALL be: score += (prev_count - cur_count), where count is the popcount of iState_flag, prev_count is registered every cycle, and a negative difference adds 0.
REQ-024 An iSpecial_attacked rising edge in PLAY while oSpecial_block=1 SHALL add 10 to the score and clear oSpecial_block in the same cycle.
REQ-025 Score SHALL saturate at 16'hFFFF and never wrap.
REQ-026 DIE: oBall_run=0; oLives SHALL decrement by 1 on entry.
REQ-027 DIE exit: if oLives was 1 on entry, SHALL go to OVER immediately; otherwise SHALL go to SERVE after WAIT_FRAMES ticks. The field SHALL NOT be reloaded.
REQ-028 CLEAR: oBall_run=0; after WAIT_FRAMES ticks, SHALL go to WIN if oLevel==2, else increment oLevel and go to LOAD.
REQ-029 OVER and WIN: SHALL hold all outputs; an iStart rising edge SHALL go to IDLE.
REQ-030 The frame counter SHALL clear on every state entry and SHALL count only iFrame_tick cycles.
REQ-031 If iBallDie and field-empty occur in the same cycle, CLEAR SHALL win and lives SHALL be unchanged.
REQ-032 The first prev_count after LOAD SHALL be sampled after oField_rst_n returns high, so the reload never scores.
REQ-033 iStart edges SHALL be ignored in LOAD, PLAY, DIE and CLEAR.

Reset
REQ-034 While rst=0, SHALL force: state IDLE, oLevel=0, oField_rst_n=0, oBall_run=0, oSpecial_block=0, oLives=0, oScore=0, counters=0.
REQ-035 Reset asserted mid-PLAY SHALL take effect asynchronously; first post-reset state SHALL be IDLE.

Verification
REQ-036 Reset release, iStart pulse -> LOAD, oField_rst_n low exactly 2 cycles, SERVE, oLevel=0, oLives=3, oScore=0.
REQ-037 SERVE with no iStart, 120 frame ticks -> PLAY on the tick after the 120th, oBall_run=1.
REQ-038 PLAY, popcount drops 300->297 in one cycle -> oScore=3; special edge -> oScore=13, oSpecial_block=0; second edge -> no change.
REQ-039 Three iBallDie events at LIVES_INIT=3 -> lives 2, 1, then OVER with oLives=0, oBall_run=0.
REQ-040 iState_flag forced to 0 together with iBallDie at level 2 -> CLEAR, oLives unchanged, after 60 ticks WIN.
REQ-041 Score preloaded at 16'hFFFA, special hit -> oScore=16'hFFFF.
